sync_start_fsm: RTL and testbench
=================================

Name: sync_start_fsm

Overview:
Parametrised start-of-stream detector for the DSP serializer path. It qualifies a run of consecutive `is_matching` cycles against minimum and maximum lengths, then enters a RUNNING phase. RUNNING lasts either a programmable number of enabled cycles or forever. The block emits state flags, one-cycle event pulses and the measured match length to the downstream serializer control.

Parameters:
- CNT_W, 16: width of the match/run counters, `run_len` and `match_len`.
- MIN_MATCH, 1: minimum consecutive enabled matching cycles for a qualifying match. Legal range 1..2^CNT_W-1.
- MAX_MATCH, 0: maximum allowed consecutive matching cycles; a longer run is rejected. 0 means unlimited.

Ports:
- clk, input, 1: clock.
- rst, input, 1: reset, synchronous, active-high.
- ena, input, 1: cycle enable. All state and counter updates happen only when ena=1.
- is_matching, input, 1: pattern match indication from the comparator.
- run_len, input, CNT_W: RUNNING duration in enabled cycles; 0 means infinite. Sampled on entry to RUNNING.
- is_waiting, output, 1: state == WAITING.
- is_matching_phase, output, 1: state == MATCHING.
- is_running, output, 1: state == RUNNING.
- is_done, output, 1: state == DONE.
- is_reject, output, 1: state == REJECT.
- start_pulse, output, 1: high for exactly the first clk cycle in RUNNING.
- done_pulse, output, 1: high for exactly the first clk cycle in DONE.
- err_pulse, output, 1: high for exactly the first clk cycle in REJECT.
- match_len, output, CNT_W: length of the last qualifying match, latched on entry to RUNNING.

Behaviour:
- States: WAITING, MATCHING, RUNNING, DONE, REJECT, 3-bit encoded. Any illegal encoding goes to WAITING on the next enabled cycle.
- Status flags are combinational decodes of the registered state; exactly one is high at any time.
- Pulses are registered and aligned with the new state.
- Reset values:
  - state = WAITING, so is_waiting=1 and all other flags 0.
  - All pulses 0.
  - match_cnt, run_cnt, match_len and the latched run_len all 0.
- Reset takes priority over ena. Reset in any state, including mid-run, returns to WAITING on the next edge.
- ena=0: state, counters and latches hold. Pulses deassert; a pulse always lasts exactly one clk.
- WAITING:
  - is_matching=1: go to MATCHING, match_cnt=1.
  - Otherwise stay.
- MATCHING, is_matching=1:
  - If MAX_MATCH≠0 and match_cnt==MAX_MATCH: go to REJECT, err_pulse.
  - Else match_cnt+1, saturating at 2^CNT_W-1.
- MATCHING, is_matching=0:
  - If match_cnt≥MIN_MATCH: go to RUNNING, match_len=match_cnt, run_cnt=0, latch run_len, start_pulse.
  - Else (glitch): go to WAITING, match_cnt=0, no pulse.
- RUNNING:
  - is_matching is ignored.
  - If latched run_len≠0 and run_cnt==run_len-1: go to DONE, done_pulse.
  - Else run_cnt+1.
  - Latched run_len=0: stay forever, run_cnt wraps modulo 2^CNT_W.
  - The RUNNING dwell is exactly run_len enabled cycles.
- DONE: terminal unless the optional feature is enabled.
- REJECT:
  - Stay while is_matching=1.
  - is_matching=0: go to WAITING, match_cnt=0.
  - A new match needs at least one non-matching cycle first.
- match_len holds its value until the next qualifying match or reset.

Optional Feature:
- Macro SYNC_START_AUTO_REARM_EN.
- Defined: DONE lasts one enabled cycle, then goes to WAITING regardless of is_matching. match_cnt and run_cnt clear; match_len is kept. The detector then qualifies the next match.
- Undefined: DONE is held until rst; is_done stays 1.

Test Plan:
All cases use MIN_MATCH=3, MAX_MATCH=8, ena=1 unless stated.
1. Reset: rst high for 2 cycles, then low. Required: is_waiting=1, all other flags and pulses 0, match_len=0.
2. Glitch rejection: is_matching high for 2 cycles, then low. Required: MATCHING for 2 cycles, then WAITING; start_pulse never asserts; match_len stays 0.
3. Qualifying match: is_matching high for 5 cycles, then low, run_len=4. Required: start_pulse for 1 cycle, match_len=5, is_running for exactly 4 cycles, then done_pulse for 1 cycle and is_done=1 held (macro undefined).
4. Overlong match: is_matching high for 12 cycles. Required: err_pulse on the cycle after the 9th high sample; is_reject held until is_matching falls, then is_waiting.
5. Enable gating: run_len=4, ena=0 for 3 cycles mid-RUNNING. Required: is_running lasts 7 clk; no duplicate pulses. Also, run_len changed to 10 during RUNNING has no effect.
6. Infinite run and re-arm: run_len=0, stay RUNNING for 100 cycles, then rst mid-run. Required: is_waiting on the next cycle. With SYNC_START_AUTO_REARM_EN and run_len=2: DONE lasts 1 cycle, then WAITING, and a second 4-cycle match yields a second start_pulse with match_len=4.

Source files
------------

// File: rtl/sync_start_fsm.sv
// Start-of-stream detector: qualifies a run of matching cycles, then runs for run_len enabled cycles.
// Optional macro SYNC_START_AUTO_REARM_EN: DONE returns to WAITING after one enabled cycle.
module sync_start_fsm #(
  parameter int unsigned CNT_W     = 16,
  parameter int unsigned MIN_MATCH = 1,
  parameter int unsigned MAX_MATCH = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic             is_matching,
  input  logic [CNT_W-1:0] run_len,
  output logic             is_waiting,
  output logic             is_matching_phase,
  output logic             is_running,
  output logic             is_done,
  output logic             is_reject,
  output logic             start_pulse,
  output logic             done_pulse,
  output logic             err_pulse,
  output logic [CNT_W-1:0] match_len
);

  typedef enum logic [2:0] {
    S_WAITING  = 3'd0,
    S_MATCHING = 3'd1,
    S_RUNNING  = 3'd2,
    S_DONE     = 3'd3,
    S_REJECT   = 3'd4
  } state_e;

  localparam logic [CNT_W-1:0] MIN_C = CNT_W'(MIN_MATCH);
  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_MATCH);
  localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] match_cnt_q, match_cnt_d;
  logic [CNT_W-1:0] run_cnt_q, run_cnt_d;
  logic [CNT_W-1:0] match_len_q, match_len_d;
  logic [CNT_W-1:0] run_len_q, run_len_d;
  logic             start_q, start_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_WAITING;
      match_cnt_q <= '0;
      run_cnt_q   <= '0;
      match_len_q <= '0;
      run_len_q   <= '0;
      start_q     <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      match_cnt_q <= match_cnt_d;
      run_cnt_q   <= run_cnt_d;
      match_len_q <= match_len_d;
      run_len_q   <= run_len_d;
      start_q     <= start_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  // Hold defaults double as the ena=0 behaviour; pulses default low so they never stretch.
  always_comb begin
    state_d     = state_q;
    match_cnt_d = match_cnt_q;
    run_cnt_d   = run_cnt_q;
    match_len_d = match_len_q;
    run_len_d   = run_len_q;
    start_d     = 1'b0;
    done_d      = 1'b0;
    err_d       = 1'b0;
    if (ena) begin
      case (state_q)
        S_WAITING: begin
          if (is_matching) begin
            state_d     = S_MATCHING;
            match_cnt_d = ONE_C;
          end
        end
        S_MATCHING: begin
          if (is_matching) begin
            if ((MAX_MATCH != 0) && (match_cnt_q == MAX_C)) begin
              state_d = S_REJECT;
              err_d   = 1'b1;
            end else if (match_cnt_q != '1) begin
              match_cnt_d = match_cnt_q + ONE_C;
            end
          end else if (match_cnt_q >= MIN_C) begin
            state_d     = S_RUNNING;
            match_len_d = match_cnt_q;
            run_cnt_d   = '0;
            run_len_d   = run_len;
            start_d     = 1'b1;
          end else begin
            state_d     = S_WAITING;
            match_cnt_d = '0;
          end
        end
        S_RUNNING: begin
          if ((run_len_q != '0) && (run_cnt_q == run_len_q - ONE_C)) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            run_cnt_d = run_cnt_q + ONE_C;
          end
        end
        S_DONE: begin
`ifdef SYNC_START_AUTO_REARM_EN
          state_d     = S_WAITING;
          match_cnt_d = '0;
          run_cnt_d   = '0;
`endif
        end
        S_REJECT: begin
          if (!is_matching) begin
            state_d     = S_WAITING;
            match_cnt_d = '0;
          end
        end
        default: state_d = S_WAITING;
      endcase
    end
  end

  assign is_waiting        = (state_q == S_WAITING);
  assign is_matching_phase = (state_q == S_MATCHING);
  assign is_running        = (state_q == S_RUNNING);
  assign is_done           = (state_q == S_DONE);
  assign is_reject         = (state_q == S_REJECT);
  assign start_pulse       = start_q;
  assign done_pulse        = done_q;
  assign err_pulse         = err_q;
  assign match_len         = match_len_q;

endmodule

// File: tb/tb_sync_start_fsm.sv
// Bench for sync_start_fsm: directed vectors, per-cycle model comparison and literal expectations.
module tb_sync_start_fsm;
  localparam int CW   = 16;
  localparam int MINM = 3;
  localparam int MAXM = 8;
  localparam int P_W = 0, P_M = 1, P_R = 2, P_D = 3, P_X = 4;

  logic          clk = 1'b0;
  logic          rst, ena, is_matching;
  logic [CW-1:0] run_len;
  logic          is_waiting, is_matching_phase, is_running, is_done, is_reject;
  logic          start_pulse, done_pulse, err_pulse;
  logic [CW-1:0] match_len;

  int checks = 0;
  int errors = 0;
  int run_cycles = 0;
  int n_start = 0, n_done = 0, n_err = 0;

  sync_start_fsm #(.CNT_W(CW), .MIN_MATCH(MINM), .MAX_MATCH(MAXM)) dut (
    .clk(clk), .rst(rst), .ena(ena), .is_matching(is_matching), .run_len(run_len),
    .is_waiting(is_waiting), .is_matching_phase(is_matching_phase), .is_running(is_running),
    .is_done(is_done), .is_reject(is_reject), .start_pulse(start_pulse),
    .done_pulse(done_pulse), .err_pulse(err_pulse), .match_len(match_len)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: phase plus streak length and a countdown of remaining RUNNING cycles.
  int m_phase, m_streak, m_remain, m_len;
  bit m_inf, m_start, m_done, m_err;
  bit m_valid = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_valid = 1'b1; m_phase = P_W; m_streak = 0; m_remain = 0; m_len = 0;
      m_inf = 1'b0; m_start = 1'b0; m_done = 1'b0; m_err = 1'b0;
    end else if (m_valid) begin
      m_start = 1'b0; m_done = 1'b0; m_err = 1'b0;
      if (ena) begin
        case (m_phase)
          P_W: if (is_matching) begin m_phase = P_M; m_streak = 1; end
          P_M: begin
            if (is_matching) begin
              if (m_streak == MAXM) begin m_phase = P_X; m_err = 1'b1; end
              else if (m_streak < (1 << CW) - 1) m_streak++;
            end else if (m_streak >= MINM) begin
              m_phase = P_R; m_len = m_streak; m_start = 1'b1;
              m_remain = int'(run_len); m_inf = (run_len == 0);
            end else begin
              m_phase = P_W; m_streak = 0;
            end
          end
          P_R: if (!m_inf) begin
            m_remain--;
            if (m_remain == 0) begin m_phase = P_D; m_done = 1'b1; end
          end
          P_D: begin
`ifdef SYNC_START_AUTO_REARM_EN
            m_phase = P_W; m_streak = 0;
`endif
          end
          default: if (!is_matching) begin m_phase = P_W; m_streak = 0; end
        endcase
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("flags_pulses",
          {24'd0, is_waiting, is_matching_phase, is_running, is_done, is_reject,
           start_pulse, done_pulse, err_pulse},
          {24'd0, m_phase == P_W, m_phase == P_M, m_phase == P_R, m_phase == P_D,
           m_phase == P_X, m_start, m_done, m_err});
      chk("match_len", {16'd0, match_len}, m_len);
      chk("onehot", $countones({is_waiting, is_matching_phase, is_running, is_done, is_reject}), 1);
      n_start += int'(start_pulse);
      n_done  += int'(done_pulse);
      n_err   += int'(err_pulse);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (is_running) run_cycles++;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic run_out(input string name);
    int guard;
    guard = 0;
    while (is_running && guard < 200) begin tick(); guard++; end
    if (guard >= 200) chk({name, "_timeout"}, 1, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1; tick(); rst = 1'b0;
  endtask

  int s0, d0, e0;

  initial begin
    rst = 1'b1; ena = 1'b1; is_matching = 1'b0; run_len = 16'd4;
    // 1. reset
    ticks(2); rst = 1'b0;
    chk("rst_flags", {is_waiting, is_matching_phase, is_running, is_done, is_reject}, 5'b10000);
    chk("rst_pulses", {start_pulse, done_pulse, err_pulse}, 3'b000);
    chk("rst_len", match_len, 0);
    // 2. glitch
    is_matching = 1'b1; tick(); chk("gl_m1", is_matching_phase, 1);
    tick(); chk("gl_m2", is_matching_phase, 1);
    is_matching = 1'b0; tick();
    chk("gl_wait", is_waiting, 1); chk("gl_nostart", start_pulse, 0); chk("gl_len", match_len, 0);
    // 3. qualifying match, run_len=4
    run_len = 16'd4; is_matching = 1'b1; ticks(5); is_matching = 1'b0;
    run_cycles = 0; tick();
    chk("q_start", start_pulse, 1); chk("q_len", match_len, 5); chk("q_run", is_running, 1);
    run_out("q");
    chk("q_cycles", run_cycles, 4); chk("q_done_p", done_pulse, 1); chk("q_done", is_done, 1);
    tick(); chk("q_done_p_off", done_pulse, 0);
`ifdef SYNC_START_AUTO_REARM_EN
    chk("q_rearm", is_waiting, 1);
`else
    ticks(5); chk("q_done_hold", is_done, 1); chk("q_len_hold", match_len, 5);
`endif
    // 4. overlong match
    do_reset(); e0 = n_err;
    is_matching = 1'b1; ticks(8);
    chk("ov_m8", is_matching_phase, 1); chk("ov_noerr", err_pulse, 0);
    tick(); chk("ov_err_p", err_pulse, 1); chk("ov_rej", is_reject, 1);
    ticks(3); chk("ov_rej_hold", is_reject, 1); chk("ov_err_off", err_pulse, 0);
    is_matching = 1'b0; tick(); chk("ov_wait", is_waiting, 1);
    chk("ov_err_cnt", n_err - e0, 1);
    // 5. enable gating right after the start pulse, run_len changed mid-run
    run_len = 16'd4; is_matching = 1'b1; ticks(3); is_matching = 1'b0;
    s0 = n_start; d0 = n_done; run_cycles = 0;
    tick(); chk("en_start", start_pulse, 1);
    ena = 1'b0; run_len = 16'd10; ticks(3);
    chk("en_hold", is_running, 1); chk("en_pulse_off", start_pulse, 0);
    ena = 1'b1; run_out("en");
    chk("en_cycles", run_cycles, 7); chk("en_done", is_done, 1); chk("en_len", match_len, 3);
    tick(); chk("en_nstart", n_start - s0, 1); chk("en_ndone", n_done - d0, 1);
    // 6. infinite run then reset mid-run
    do_reset(); run_len = 16'd0;
    is_matching = 1'b1; ticks(3); is_matching = 1'b0; tick();
    run_cycles = 0; d0 = n_done; ticks(100);
    chk("inf_cycles", run_cycles, 100); chk("inf_nodone", n_done - d0, 0);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("inf_rst", is_waiting, 1); chk("inf_rst_len", match_len, 0);
`ifdef SYNC_START_AUTO_REARM_EN
    run_len = 16'd2; is_matching = 1'b1; ticks(3); is_matching = 1'b0;
    tick(); chk("ra_run", is_running, 1);
    tick(); tick(); chk("ra_done", is_done, 1);
    tick(); chk("ra_wait", is_waiting, 1); chk("ra_len_kept", match_len, 3);
    is_matching = 1'b1; ticks(4); is_matching = 1'b0; tick();
    chk("ra_start2", start_pulse, 1); chk("ra_len2", match_len, 4);
`endif
    ticks(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule
